ai_threat_fusion: RTL

- Downstream consumer of the vision, audio and motion AI cores.
- Captures each core's result on its done pulse and waits a bounded window for the other sources.
- Computes a weighted fused threat score and an alert level from the captured results.
- Presents one alert record per fusion on a valid/ready handshake to the alert/host controller.

---
 rtl/ai_fusion_pkg.sv | 36 +++
 rtl/ai_fusion_slot.sv | 54 +++++
 rtl/ai_threat_fusion.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ai_fusion_pkg.sv
// ============================================================================
// Module      : ai_fusion_pkg
// Description : Shared encodings for the AI threat fusion block: alert
//               levels, fusion FSM states, source indices and score scaling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ai_fusion_pkg;

    // Alert level encoding presented on alert_level
    localparam logic [1:0] ALERT_NONE = 2'd0;
    localparam logic [1:0] ALERT_LOW  = 2'd1;
    localparam logic [1:0] ALERT_MED  = 2'd2;
    localparam logic [1:0] ALERT_HIGH = 2'd3;

    // Fusion controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FUSE    = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    // Slot index of each source; also the bit position in source_mask
    localparam int SRC_VISION = 0;
    localparam int SRC_AUDIO  = 1;
    localparam int SRC_MOTION = 2;
    localparam int NUM_SRC    = 3;

    // Weighted sum is scaled down by 2^SCORE_SHIFT before saturation
    localparam int SCORE_SHIFT = 4;

endpackage : ai_fusion_pkg

`default_nettype wire

// File: rtl/ai_fusion_slot.sv
// ============================================================================
// Module      : ai_fusion_slot
// Description : One source capture slot: data/score register, valid bit and
//               a combinational overrun flag for an overwrite of live data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ai_fusion_slot #(
    parameter int DATA_W  = 32,
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic [DATA_W-1:0]  i_data,
    input  logic [SCORE_W-1:0] i_score,
    output logic               o_valid,
    output logic [DATA_W-1:0]  o_data,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_overrun
);

    logic               r_valid;
    logic [DATA_W-1:0]  r_data;
    logic [SCORE_W-1:0] r_score;

    // Capture on load; a load coincident with a clear (consume) wins and
    // keeps the slot valid with the fresh data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_score <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_score <= i_score;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    // Overwriting live data is an overrun, unless the slot is being consumed
    // on the same edge.
    assign o_overrun = i_load & r_valid & ~i_clear;
    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_score   = r_score;

endmodule : ai_fusion_slot

`default_nettype wire

// File: rtl/ai_threat_fusion.sv
// ============================================================================
// Module      : ai_threat_fusion
// Description : Collects vision/audio/motion AI results within a bounded
//               window, fuses them into a weighted saturated threat score
//               and alert level, and presents one alert record per fusion
//               on a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ai_threat_fusion
    import ai_fusion_pkg::*;
#(
    parameter logic [3:0]  W_VISION      = 4'd6,
    parameter logic [3:0]  W_AUDIO       = 4'd6,
    parameter logic [3:0]  W_MOTION      = 4'd4,
    parameter logic [15:0] WINDOW_CYCLES = 16'd1024,
    parameter logic [7:0]  THR_LOW       = 8'd64,
    parameter logic [7:0]  THR_MED       = 8'd128,
    parameter logic [7:0]  THR_HIGH      = 8'd192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] vision_result,
    input  logic [7:0]  vision_confidence,
    input  logic        vision_done,
    input  logic [31:0] audio_classification,
    input  logic [7:0]  audio_threat_level,
    input  logic        audio_complete,
    input  logic [31:0] motion_pattern,
    input  logic [7:0]  motion_anomaly,
    input  logic        motion_done,
    output logic        alert_valid,
    input  logic        alert_ready,
    output logic [1:0]  alert_level,
    output logic [7:0]  fused_score,
    output logic [2:0]  source_mask,
    output logic [31:0] vision_result_q,
    output logic [31:0] audio_class_q,
    output logic [31:0] motion_pattern_q,
    output logic [7:0]  overrun_count,
    output logic        fusion_busy
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_win_cnt;
    logic [7:0]  r_ovr_cnt;
    logic [1:0]  r_level;
    logic [7:0]  r_score;
    logic [2:0]  r_mask;
    logic [31:0] r_vis_q;
    logic [31:0] r_aud_q;
    logic [31:0] r_mot_q;

    logic [NUM_SRC-1:0] w_done;
    logic [NUM_SRC-1:0] w_valid;
    logic [NUM_SRC-1:0] w_overrun;
    logic [31:0]        w_in_data    [NUM_SRC];
    logic [7:0]         w_in_score   [NUM_SRC];
    logic [31:0]        w_slot_data  [NUM_SRC];
    logic [7:0]         w_slot_score [NUM_SRC];
    logic               w_fuse;

    assign w_done[SRC_VISION]     = vision_done;
    assign w_done[SRC_AUDIO]      = audio_complete;
    assign w_done[SRC_MOTION]     = motion_done;
    assign w_in_data[SRC_VISION]  = vision_result;
    assign w_in_data[SRC_AUDIO]   = audio_classification;
    assign w_in_data[SRC_MOTION]  = motion_pattern;
    assign w_in_score[SRC_VISION] = vision_confidence;
    assign w_in_score[SRC_AUDIO]  = audio_threat_level;
    assign w_in_score[SRC_MOTION] = motion_anomaly;

    // All slots are consumed during the single FUSE cycle
    assign w_fuse = (r_state == FUSE);

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
        ai_fusion_slot #(
            .DATA_W  (32),
            .SCORE_W (8)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .i_load    (w_done[gi]),
            .i_clear   (w_fuse),
            .i_data    (w_in_data[gi]),
            .i_score   (w_in_score[gi]),
            .o_valid   (w_valid[gi]),
            .o_data    (w_slot_data[gi]),
            .o_score   (w_slot_score[gi]),
            .o_overrun (w_overrun[gi])
        );
    end

    // ------------------------------------------------------------------
    // Score arithmetic: invalid slots contribute zero
    // ------------------------------------------------------------------
    logic [7:0]  w_eff_v, w_eff_a, w_eff_m;
    logic [11:0] w_prod_v, w_prod_a, w_prod_m;
    logic [13:0] w_sum;
    logic [13:0] w_shifted;
    logic [7:0]  w_score;
    logic [1:0]  w_level;

    assign w_eff_v   = w_valid[SRC_VISION] ? w_slot_score[SRC_VISION] : 8'd0;
    assign w_eff_a   = w_valid[SRC_AUDIO]  ? w_slot_score[SRC_AUDIO]  : 8'd0;
    assign w_eff_m   = w_valid[SRC_MOTION] ? w_slot_score[SRC_MOTION] : 8'd0;
    assign w_prod_v  = {8'd0, W_VISION} * {4'd0, w_eff_v};
    assign w_prod_a  = {8'd0, W_AUDIO}  * {4'd0, w_eff_a};
    assign w_prod_m  = {8'd0, W_MOTION} * {4'd0, w_eff_m};
    assign w_sum     = {2'd0, w_prod_v} + {2'd0, w_prod_a} + {2'd0, w_prod_m};
    assign w_shifted = w_sum >> SCORE_SHIFT;
    assign w_score   = (w_shifted > 14'd255) ? 8'hFF : w_shifted[7:0];

    // Map the saturated score onto the alert level thresholds
    always_comb begin
        w_level = ALERT_NONE;
        if (w_score >= THR_HIGH) begin
            w_level = ALERT_HIGH;
        end else if (w_score >= THR_MED) begin
            w_level = ALERT_MED;
        end else if (w_score >= THR_LOW) begin
            w_level = ALERT_LOW;
        end
    end

    // ------------------------------------------------------------------
    // Fusion FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a done pulse in IDLE opens the window on that same
    // edge so a full set of results reaches OUTPUT two edges later.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if ((|w_done) || (|w_valid)) begin
                    w_next = COLLECT;
                end
            end
            COLLECT: begin
                if (&w_valid) begin
                    w_next = FUSE;
                end else if (r_win_cnt == 16'd0) begin
                    w_next = FUSE;
                end
            end
            FUSE: begin
                w_next = OUTPUT;
            end
            OUTPUT: begin
                if (alert_ready) begin
                    w_next = ((|w_valid) || (|w_done)) ? COLLECT : IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Window counter: reload on entry to COLLECT, count down while waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_cnt <= 16'd0;
        end else if ((w_next == COLLECT) && (r_state != COLLECT)) begin
            r_win_cnt <= WINDOW_CYCLES;
        end else if ((r_state == COLLECT) && (w_next == COLLECT)) begin
            r_win_cnt <= r_win_cnt - 16'd1;
        end
    end

    // Saturating count of overwritten slots (several may overrun at once)
    logic [1:0] w_ovr_inc;
    logic [8:0] w_ovr_sum;
    assign w_ovr_inc = {1'b0, w_overrun[0]} + {1'b0, w_overrun[1]} + {1'b0, w_overrun[2]};
    assign w_ovr_sum = {1'b0, r_ovr_cnt} + {7'd0, w_ovr_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovr_cnt <= 8'd0;
        end else begin
            r_ovr_cnt <= w_ovr_sum[8] ? 8'hFF : w_ovr_sum[7:0];
        end
    end

    // Alert record is captured in FUSE and held untouched through OUTPUT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= ALERT_NONE;
            r_score <= 8'd0;
            r_mask  <= 3'd0;
            r_vis_q <= 32'd0;
            r_aud_q <= 32'd0;
            r_mot_q <= 32'd0;
        end else if (w_fuse) begin
            r_level <= w_level;
            r_score <= w_score;
            r_mask  <= w_valid;
            r_vis_q <= w_valid[SRC_VISION] ? w_slot_data[SRC_VISION] : 32'd0;
            r_aud_q <= w_valid[SRC_AUDIO]  ? w_slot_data[SRC_AUDIO]  : 32'd0;
            r_mot_q <= w_valid[SRC_MOTION] ? w_slot_data[SRC_MOTION] : 32'd0;
        end
    end

    assign alert_valid      = (r_state == OUTPUT);
    assign fusion_busy      = (r_state != IDLE);
    assign alert_level      = r_level;
    assign fused_score      = r_score;
    assign source_mask      = r_mask;
    assign vision_result_q  = r_vis_q;
    assign audio_class_q    = r_aud_q;
    assign motion_pattern_q = r_mot_q;
    assign overrun_count    = r_ovr_cnt;

endmodule : ai_threat_fusion

`default_nettype wire
